// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
// Game sequencer for the snake datapath. A MENU/INIT/PLAY/PAUSE/OVER state
// machine drives the datapath controls. A level-dependent move tick paces
// the snake. Score, level and high score are kept from the datapath's
// apple_eaten and collision events.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        level input; a rising edge is the start/return command
//   pause        level input; a rising edge toggles PLAY/PAUSE
//   collision    datapath collision (level)
//   apple_eaten  one-cycle pulse per apple consumed
//   inmenu       datapath: clear snake arrays/apple
//   ingame       datapath: run game logic
//   head_init    datapath: 0 = load initial head position
//   move_tick    one-cycle snake-advance strobe
//   game_over    game has ended
//   state        MENU=0, INIT=1, PLAY=2, PAUSE=3, OVER=4
//   score        apples this game, saturating at 255
//   hi_score     best score since reset
//   level        current speed level, 0..LEVEL_MAX
module snake_game_ctrl #(
  parameter int unsigned TICK_BASE        = 2520000,
  parameter int unsigned TICK_STEP        = 240000,
  parameter int unsigned TICK_MIN         = 600000,
  parameter int unsigned APPLES_PER_LEVEL = 4,
  parameter int unsigned LEVEL_MAX        = 7,
  parameter int unsigned INIT_CYCLES      = 16,
  parameter int unsigned CNT_W            = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  input  logic       apple_eaten,
  output logic       inmenu,
  output logic       ingame,
  output logic       head_init,
  output logic       move_tick,
  output logic       game_over,
  output logic [2:0] state,
  output logic [7:0] score,
  output logic [7:0] hi_score,
  output logic [3:0] level
);

  localparam logic [2:0] S_MENU  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  // Period arithmetic gets 4 spare bits so level*TICK_STEP cannot wrap.
  localparam int unsigned PW = CNT_W + 4;
  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned AW = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;

  localparam logic [CNT_W-1:0] TICK_LOAD  = CNT_W'(TICK_BASE - 1);
  localparam logic [IW-1:0]    INIT_LOAD  = IW'(INIT_CYCLES - 1);
  localparam logic [AW-1:0]    APPLE_LAST = AW'(APPLES_PER_LEVEL - 1);
  localparam logic [3:0]       LVL_TOP    = 4'(LEVEL_MAX);

  logic [2:0]       state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       hi_q, hi_d;
  logic [3:0]       level_q, level_d;
  logic [AW-1:0]    apples_q, apples_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             start_q, pause_q;
  logic             start_edge, pause_edge;

  // Reload value (period-1) for a given level. The subtraction is guarded so
  // a large level*TICK_STEP clamps to TICK_MIN instead of underflowing.
  function automatic logic [CNT_W-1:0] reload_val(input logic [3:0] lvl);
    logic [PW-1:0] red;
    logic [PW-1:0] per;
    red = PW'(lvl) * PW'(TICK_STEP);
    if (red >= PW'(TICK_BASE)) begin
      per = PW'(TICK_MIN);
    end else begin
      per = PW'(TICK_BASE) - red;
      if (per < PW'(TICK_MIN)) per = PW'(TICK_MIN);
    end
    return CNT_W'(per - PW'(1));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_level(input logic [3:0] v);
    return (v >= LVL_TOP) ? v : v + 4'd1;
  endfunction

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    hi_d       = hi_q;
    level_d    = level_q;
    apples_d   = apples_q;
    init_cnt_d = init_cnt_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      S_MENU: begin
        if (start_edge) begin
          state_d    = S_INIT;
          score_d    = 8'd0;
          level_d    = 4'd0;
          apples_d   = '0;
          init_cnt_d = INIT_LOAD;
        end
      end
      S_INIT: begin
        if (init_cnt_q == '0) begin
          state_d    = S_PLAY;
          tick_cnt_d = TICK_LOAD;
        end else begin
          init_cnt_d = init_cnt_q - 1'b1;
        end
      end
      S_PLAY: begin
        // Reload uses the registered level, so a level change lands only at
        // the next reload.
        if (tick_cnt_q == '0) tick_cnt_d = reload_val(level_q);
        else                  tick_cnt_d = tick_cnt_q - 1'b1;
        if (apple_eaten) begin
          score_d = sat_inc8(score_q);
          if (apples_q == APPLE_LAST) begin
            apples_d = '0;
            level_d  = sat_level(level_q);
          end else begin
            apples_d = apples_q + 1'b1;
          end
        end
        // score_d already includes a coincident apple.
        if (collision) begin
          state_d = S_OVER;
          if (score_d > hi_q) hi_d = score_d;
        end else if (pause_edge) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_edge) state_d = S_PLAY;
      end
      S_OVER: begin
        if (start_edge) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Edge registers reset high so a level held through reset is not an edge.
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
      state_q    <= S_MENU;
      score_q    <= 8'd0;
      hi_q       <= 8'd0;
      level_q    <= 4'd0;
      apples_q   <= '0;
      init_cnt_q <= INIT_LOAD;
      tick_cnt_q <= TICK_LOAD;
    end else begin
      start_q    <= start;
      pause_q    <= pause;
      state_q    <= state_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      level_q    <= level_d;
      apples_q   <= apples_d;
      init_cnt_q <= init_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign hi_score  = hi_q;
  assign level     = level_q;
  assign inmenu    = (state_q == S_MENU);
  assign ingame    = (state_q == S_INIT) || (state_q == S_PLAY) ||
                     (state_q == S_PAUSE) || (state_q == S_OVER);
  assign head_init = (state_q == S_PLAY) || (state_q == S_PAUSE) ||
                     (state_q == S_OVER);
  assign game_over = (state_q == S_OVER);
  assign move_tick = (state_q == S_PLAY) && (tick_cnt_q == '0);

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

  localparam int TB_BASE = 10;
  localparam int TB_STEP = 2;
  localparam int TB_MIN  = 4;
  localparam int TB_APL  = 2;
  localparam int TB_LMAX = 7;
  localparam int TB_INIT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       collision = 1'b0;
  logic       apple_eaten = 1'b0;
  logic       inmenu, ingame, head_init, move_tick, game_over;
  logic [2:0] state;
  logic [7:0] score, hi_score;
  logic [3:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  snake_game_ctrl #(
    .TICK_BASE(TB_BASE), .TICK_STEP(TB_STEP), .TICK_MIN(TB_MIN),
    .APPLES_PER_LEVEL(TB_APL), .LEVEL_MAX(TB_LMAX), .INIT_CYCLES(TB_INIT),
    .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .collision(collision), .apple_eaten(apple_eaten),
    .inmenu(inmenu), .ingame(ingame), .head_init(head_init),
    .move_tick(move_tick), .game_over(game_over), .state(state),
    .score(score), .hi_score(hi_score), .level(level)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Phase: 0 menu, 1 init, 2 play, 3 pause, 4 over.
  int m_phase = 0, m_score = 0, m_hi = 0, m_level = 0, m_apples = 0;
  int m_init_left = 0, m_remain = TB_BASE - 1;
  bit m_start_prev = 1'b1, m_pause_prev = 1'b1;

  function automatic int move_period(input int lvl);
    int p;
    p = TB_BASE - lvl * TB_STEP;
    return (p < TB_MIN) ? TB_MIN : p;
  endfunction

  always @(posedge clk) begin
    bit se, pe;
    if (reset) begin
      m_phase = 0; m_score = 0; m_hi = 0; m_level = 0; m_apples = 0;
      m_init_left = TB_INIT - 1; m_remain = TB_BASE - 1;
      m_start_prev = 1'b1; m_pause_prev = 1'b1;
    end else begin
      se = start && !m_start_prev;
      pe = pause && !m_pause_prev;
      case (m_phase)
        0: if (se) begin
             m_phase = 1; m_score = 0; m_level = 0; m_apples = 0;
             m_init_left = TB_INIT - 1;
           end
        1: if (m_init_left == 0) begin m_phase = 2; m_remain = TB_BASE - 1; end
           else m_init_left--;
        2: begin
             m_remain = (m_remain == 0) ? move_period(m_level) - 1 : m_remain - 1;
             if (apple_eaten) begin
               if (m_score < 255) m_score++;
               m_apples++;
               if (m_apples == TB_APL) begin
                 m_apples = 0;
                 if (m_level < TB_LMAX) m_level++;
               end
             end
             if (collision) begin
               m_phase = 4;
               if (m_score > m_hi) m_hi = m_score;
             end else if (pe) m_phase = 3;
           end
        3: if (pe) m_phase = 2;
        4: if (se) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_start_prev = start;
      m_pause_prev = pause;
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    logic [27:0] act, exp;
    if (check_en) begin
      act = {state, score, hi_score, level, inmenu, ingame, head_init, move_tick, game_over};
      exp = {3'(m_phase), 8'(m_score), 8'(m_hi), 4'(m_level),
             m_phase == 0, m_phase != 0, m_phase >= 2,
             (m_phase == 2) && (m_remain == 0), m_phase == 4};
      check("model_cycle", 64'(act), 64'(exp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin step(); n++; end while (!move_tick && n < 200);
    if (!move_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic to_play();
    int n;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (state != 3'd2 && n < 20) begin step(); n++; end
    check("reach_play", 64'(state), 2);
  endtask

  task automatic apples(input int k);
    repeat (k) begin apple_eaten = 1'b1; step(); apple_eaten = 1'b0; step(); end
  endtask

  initial begin
    int n, ticks;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks;
    step(); check_en = 1'b1; step();
    check("reset_state", 64'(state), 0);
    check("reset_inmenu", 64'(inmenu), 1);
    check("reset_outs", 64'({ingame, head_init, move_tick, game_over}), 0);
    reset = 1'b0; step(2);

    // Start: one cycle into INIT, exactly three INIT cycles, then PLAY.
    start = 1'b1; step(); start = 1'b0;
    check("init_entry", 64'(state), 1);
    n = 0;
    while (state == 3'd1 && head_init == 1'b0 && n < 20) begin step(); n++; end
    check("init_len", 64'(n), 3);
    check("play_entry", 64'(state), 2);
    n = 1;
    while (!move_tick && n < 30) begin step(); n++; end
    check("first_tick", 64'(n), 10);
    wait_tick(n);
    check("tick_spacing_l0", 64'(n), 10);

    // Pause with the counter frozen at 5.
    n = 0;
    while (!(m_phase == 2 && m_remain == 6) && n < 30) begin step(); n++; end
    pause = 1'b1; step(); pause = 1'b0;
    check("pause_state", 64'(state), 3);
    ticks = 0;
    repeat (50) begin step(); if (move_tick) ticks++; end
    check("pause_no_tick", 64'(ticks), 0);
    check("pause_hold", 64'(state), 3);
    pause = 1'b1; step(); pause = 1'b0;
    check("resume_state", 64'(state), 2);
    wait_tick(n);
    check("resume_tick", 64'(n), 5);

    // Apples raise the level; new period after the next reload.
    apples(4);
    check("score4", 64'(score), 4);
    check("level2", 64'(level), 2);
    wait_tick(n); wait_tick(n);
    check("tick_spacing_l2", 64'(n), 6);
    apples(8);
    check("level6", 64'(level), 6);
    wait_tick(n); wait_tick(n);
    check("tick_spacing_clamp", 64'(n), 4);

    // Collision with a coincident apple: score 2 -> 3, high score 3.
    reset = 1'b1; step(); reset = 1'b0; step();
    to_play();
    apples(2);
    collision = 1'b1; apple_eaten = 1'b1; step();
    collision = 1'b0; apple_eaten = 1'b0;
    check("over_state", 64'(state), 4);
    check("over_score", 64'(score), 3);
    check("over_hi", 64'(hi_score), 3);
    check("over_flag", 64'(game_over), 1);
    ticks = 0;
    repeat (30) begin step(); if (move_tick) ticks++; end
    check("over_no_tick", 64'(ticks), 0);
    start = 1'b1; step(); start = 1'b0;
    check("over_to_menu", 64'(state), 0);
    check("menu_inmenu", 64'(inmenu), 1);
    step(); start = 1'b1; step(); start = 1'b0;
    check("new_game_score", 64'(score), 0);
    check("new_game_hi", 64'(hi_score), 3);

    // Reset during PAUSE with score 5 clears everything, hi_score included.
    n = 0;
    while (state != 3'd2 && n < 20) begin step(); n++; end
    apples(5);
    pause = 1'b1; step(); pause = 1'b0;
    check("pause5_state", 64'(state), 3);
    check("pause5_score", 64'(score), 5);
    reset = 1'b1; step();
    check("rst_mid", 64'({state, score, hi_score, level, inmenu}),
          64'({3'd0, 8'd0, 8'd0, 4'd0, 1'b1}));

    // start held high through reset release is not an edge.
    start = 1'b1; step(); reset = 1'b0; step(5);
    check("start_held", 64'(state), 0);
    start = 1'b0; step();
    check("start_fall", 64'(state), 0);
    start = 1'b1; step(); start = 1'b0;
    check("start_rise", 64'(state), 1);

    // Randomised play against the reference model.
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) start = ~start;
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      apple_eaten = ($urandom_range(0, 5) == 0);
      collision   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 999) == 0) reset = 1'b1; else reset = 1'b0;
      step();
    end
    reset = 1'b0; collision = 1'b0; apple_eaten = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
